// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, grant IDs and
// default address/data widths.
package dmem_arbiter_pkg;

    localparam int AW_DEF = 64;
    localparam int DW_DEF = 64;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin winner selector; req[0] is the CPU, req[1] the loader.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

    always_comb begin
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = GNT_LD;
        end else begin
            winner = GNT_CPU;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported data memory between the CPU and a loader/debug port.
// Each access takes IDLE -> ISSUE -> RESP; the owner gets a one-cycle done pulse.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_done,
    output logic [DW-1:0] ld_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic          cpu_done_q, cpu_done_d;
    logic          ld_done_q, ld_done_d;
    logic          winner;

    rr_arb2 u_rr_arb2 (
        .req        ({ld_req, cpu_req}),
        .last_grant (last_grant_q),
        .winner     (winner)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        cpu_done_d   = 1'b0;
        ld_done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req || ld_req) begin
                    owner_d      = winner;
                    last_grant_d = winner;
                    we_d         = (winner == GNT_LD) ? ld_we    : cpu_we;
                    addr_d       = (winner == GNT_LD) ? ld_addr  : cpu_addr;
                    wdata_d      = (winner == GNT_LD) ? ld_wdata : cpu_wdata;
                    mem_en_d     = 1'b1;
                    mem_we_d     = we_d;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cpu_done_d = (owner_q == GNT_CPU);
                ld_done_d  = (owner_q == GNT_LD);
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_LD;
            owner_q      <= GNT_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_done_q   <= 1'b0;
            ld_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            cpu_done_q   <= cpu_done_d;
            ld_done_q    <= ld_done_d;
        end
    end

    // Reset gates the write strobe immediately so an aborted store never lands.
    assign mem_we    = mem_we_q & ~reset;
    assign mem_en    = mem_en_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign cpu_done  = cpu_done_q;
    assign ld_done   = ld_done_q;
    assign cpu_rdata = (cpu_done_q && !we_q) ? mem_rdata : '0;
    assign ld_rdata  = (ld_done_q && !we_q) ? mem_rdata : '0;
    assign cpu_stall = cpu_req & ~cpu_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of single transactions, directed
// multi-cycle sequences, then random traffic against a transaction-level model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ld_req, ld_we;
    logic [63:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic        cpu_done, ld_done, cpu_stall;
    logic [63:0] cpu_rdata, ld_rdata;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = 64'h0;

    int total = 0;
    int bad   = 0;

    bit [63:0] mem_arr [32];
    bit [63:0] ref_arr [32];

    typedef struct {
        bit          port;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
    } vec_t;
    vec_t vt [9];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(64), .DW(64)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_done(ld_done), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr[7:3]] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr[7:3]];
        end
    end

    function automatic int widx(input logic [63:0] a);
        return int'(a[7:3]);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cpu_req = 1'b0; ld_req = 1'b0;
        step();
        cpu_req = 1'b1;
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_ld_done", ld_done, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ld_rdata", ld_rdata, 0);
        chk("rst_cpu_stall", cpu_stall, 1);
        step();
        reset = 1'b0; cpu_req = 1'b0;
    endtask

    task automatic run_single(input vec_t v, input int i);
        bit is_cpu;
        is_cpu = (v.port == 1'b0);
        cpu_req = is_cpu;  cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        ld_req  = !is_cpu; ld_we  = v.we; ld_addr  = v.addr; ld_wdata  = v.wdata;
        @(negedge clk);
        chk($sformatf("v%0d_n_mem_en", i), mem_en, 0);
        chk($sformatf("v%0d_n_stall", i), cpu_stall, is_cpu);
        step();
        @(negedge clk);
        chk($sformatf("v%0d_n1_mem_en", i), mem_en, 1);
        chk($sformatf("v%0d_n1_mem_we", i), mem_we, v.we);
        chk($sformatf("v%0d_n1_mem_addr", i), mem_addr, v.addr);
        chk($sformatf("v%0d_n1_mem_wdata", i), mem_wdata, v.wdata);
        chk($sformatf("v%0d_n1_stall", i), cpu_stall, is_cpu);
        chk($sformatf("v%0d_n1_done", i), {cpu_done, ld_done}, 0);
        step();
        @(negedge clk);
        chk($sformatf("v%0d_n2_cpu_done", i), cpu_done, is_cpu);
        chk($sformatf("v%0d_n2_ld_done", i), ld_done, !is_cpu);
        chk($sformatf("v%0d_n2_cpu_rdata", i), cpu_rdata, is_cpu ? v.exp_rd : 64'h0);
        chk($sformatf("v%0d_n2_ld_rdata", i), ld_rdata, is_cpu ? 64'h0 : v.exp_rd);
        chk($sformatf("v%0d_n2_stall", i), cpu_stall, 0);
        chk($sformatf("v%0d_n2_mem_en", i), mem_en, 0);
        if (v.we) ref_arr[widx(v.addr)] = v.wdata;
        step();
        cpu_req = 1'b0; ld_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_n3_done", i), {cpu_done, ld_done}, 0);
        step();
    endtask

    // Random-phase model state
    bit          pend [2];
    bit          gnt [2];
    bit          p_we [2];
    logic [63:0] p_addr [2];
    logic [63:0] p_wd [2];
    int          free_c, iss_c, done_c;
    bit          last_w, dport, iss_we, w;
    logic [63:0] iss_addr, iss_wd, done_rd;

    initial begin
        vt[0] = '{1'b1, 1'b1, 64'h8,  64'h55,                  64'h0};
        vt[1] = '{1'b1, 1'b1, 64'h10, 64'h0000_0000_DEAD_BEEF, 64'h0};
        vt[2] = '{1'b0, 1'b0, 64'h10, 64'h1234,                64'h0000_0000_DEAD_BEEF};
        vt[3] = '{1'b0, 1'b1, 64'h18, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0};
        vt[4] = '{1'b1, 1'b0, 64'h18, 64'h0,                   64'hA5A5_A5A5_5A5A_5A5A};
        vt[5] = '{1'b0, 1'b0, 64'h8,  64'h0,                   64'h55};
        vt[6] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0,  64'h0};
        vt[7] = '{1'b0, 1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vt[8] = '{1'b0, 1'b0, 64'h20, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF};

        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req  = 0; ld_we  = 0; ld_addr  = 0; ld_wdata  = 0;
        do_reset();

        for (int i = 0; i < 9; i++) run_single(vt[i], i);

        // Address change during ISSUE is ignored
        cpu_req = 1; cpu_we = 0; cpu_addr = 64'h10; ld_req = 0;
        step();
        cpu_addr = 64'h20; cpu_we = 1; cpu_wdata = 64'h99;
        @(negedge clk);
        chk("chg_mem_addr", mem_addr, 64'h10);
        chk("chg_mem_we", mem_we, 0);
        step();
        @(negedge clk);
        chk("chg_cpu_done", cpu_done, 1);
        chk("chg_cpu_rdata", cpu_rdata, 64'h0000_0000_DEAD_BEEF);
        step();
        cpu_req = 0;

        // Simultaneous requests after reset: CPU first, then loader
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 64'h8;
        ld_req  = 1; ld_we  = 0; ld_addr  = 64'h18;
        step();
        @(negedge clk);
        chk("sim_n1_mem_addr", mem_addr, 64'h8);
        chk("sim_n1_mem_en", mem_en, 1);
        step();
        @(negedge clk);
        chk("sim_n2_cpu_done", cpu_done, 1);
        chk("sim_n2_ld_done", ld_done, 0);
        chk("sim_n2_cpu_rdata", cpu_rdata, 64'h55);
        step();
        cpu_req = 0;
        @(negedge clk);
        chk("sim_n3_done", {cpu_done, ld_done}, 0);
        chk("sim_n3_mem_en", mem_en, 0);
        step();
        @(negedge clk);
        chk("sim_n4_mem_addr", mem_addr, 64'h18);
        chk("sim_n4_mem_en", mem_en, 1);
        step();
        @(negedge clk);
        chk("sim_n5_ld_done", ld_done, 1);
        chk("sim_n5_ld_rdata", ld_rdata, 64'hA5A5_A5A5_5A5A_5A5A);
        chk("sim_n5_cpu_done", cpu_done, 0);
        step();
        ld_req = 0;

        // Continuous contention: alternate grants, each port done every 6 cycles
        cpu_req = 1; cpu_addr = 64'h10; ld_req = 1; ld_addr = 64'h8;
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            chk($sformatf("cont%0d_cpu_done", j), cpu_done, (j % 6) == 2);
            chk($sformatf("cont%0d_ld_done", j), ld_done, (j % 6) == 5);
            chk($sformatf("cont%0d_cpu_rdata", j), cpu_rdata,
                ((j % 6) == 2) ? 64'h0000_0000_DEAD_BEEF : 64'h0);
            chk($sformatf("cont%0d_ld_rdata", j), ld_rdata, ((j % 6) == 5) ? 64'h55 : 64'h0);
            step();
        end
        cpu_req = 0; ld_req = 0;

        // Reset during ISSUE of a CPU store drops the access
        step();
        cpu_req = 1; cpu_we = 1; cpu_addr = 64'h28; cpu_wdata = 64'h77;
        step();
        reset = 1; cpu_req = 0;
        @(negedge clk);
        chk("rsti_mem_we", mem_we, 0);
        step();
        reset = 0;
        @(negedge clk);
        chk("rsti_cpu_done", cpu_done, 0);
        chk("rsti_mem_en", mem_en, 0);
        step();
        run_single('{1'b0, 1'b0, 64'h28, 64'h0, 64'h0}, 9);

        // Random traffic against a transaction-level model
        do_reset();
        last_w = 1'b1; free_c = 0; iss_c = -10; done_c = -10; dport = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; gnt[p] = 0; p_we[p] = 0; p_addr[p] = 0; p_wd[p] = 0;
        end
        for (int k = 0; k < 600; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && done_c == k - 1 && dport == p[0]) pend[p] = 0;
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        pend[p]   = 1; gnt[p] = 0;
                        p_we[p]   = $urandom_range(0, 1) == 1;
                        p_addr[p] = {$urandom, $urandom};
                        p_wd[p]   = {$urandom, $urandom};
                    end
                end else if (gnt[p]) begin
                    p_we[p]   = $urandom_range(0, 1) == 1;
                    p_addr[p] = {$urandom, $urandom};
                    p_wd[p]   = {$urandom, $urandom};
                end
            end
            cpu_req = pend[0]; cpu_we = p_we[0]; cpu_addr = p_addr[0]; cpu_wdata = p_wd[0];
            ld_req  = pend[1]; ld_we  = p_we[1]; ld_addr  = p_addr[1]; ld_wdata  = p_wd[1];
            if (k >= free_c && (pend[0] || pend[1])) begin
                w = (pend[0] && pend[1]) ? ~last_w : pend[1];
                last_w   = w;
                gnt[w]   = 1;
                iss_c    = k + 1;
                done_c   = k + 2;
                free_c   = k + 3;
                dport    = w;
                iss_we   = p_we[w];
                iss_addr = p_addr[w];
                iss_wd   = p_wd[w];
                done_rd  = iss_we ? 64'h0 : ref_arr[widx(iss_addr)];
                if (iss_we) ref_arr[widx(iss_addr)] = iss_wd;
            end
            @(negedge clk);
            chk($sformatf("rnd%0d_mem_en", k), mem_en, k == iss_c);
            if (k == iss_c) begin
                chk($sformatf("rnd%0d_mem_we", k), mem_we, iss_we);
                chk($sformatf("rnd%0d_mem_addr", k), mem_addr, iss_addr);
                chk($sformatf("rnd%0d_mem_wdata", k), mem_wdata, iss_wd);
            end
            chk($sformatf("rnd%0d_cpu_done", k), cpu_done, k == done_c && dport == 0);
            chk($sformatf("rnd%0d_ld_done", k), ld_done, k == done_c && dport == 1);
            chk($sformatf("rnd%0d_cpu_rdata", k), cpu_rdata,
                (k == done_c && dport == 0) ? done_rd : 64'h0);
            chk($sformatf("rnd%0d_ld_rdata", k), ld_rdata,
                (k == done_c && dport == 1) ? done_rd : 64'h0);
            chk($sformatf("rnd%0d_stall", k), cpu_stall,
                pend[0] && !(k == done_c && dport == 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
